// File: rtl/select_parents.sv
// rtl/select_parents.sv - collects one tour distance per member, reports the two shortest
module select_parents #(
    parameter int POP_SIZE = 8,
    parameter int IDX_W    = 3,
    parameter int DIST_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_in,
    output logic [IDX_W:0]    count,
    output logic              busy,
    output logic              sel_done,
    output logic [IDX_W-1:0]  best_idx,
    output logic [DIST_W-1:0] best_dist,
    output logic [IDX_W-1:0]  second_idx,
    output logic [DIST_W-1:0] second_dist,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, COLLECT, SCAN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [DIST_W-1:0] mem [POP_SIZE];
    logic [IDX_W-1:0]  scan_ptr;
    logic [DIST_W-1:0] cur;
    logic              last_accept;
    logic              scan_last;
    logic              accept;

    assign accept      = (state == COLLECT) && dist_valid && !start;
    assign last_accept = accept && (count == (IDX_W+1)'(POP_SIZE - 1));
    assign scan_last   = (scan_ptr == IDX_W'(POP_SIZE - 1));
    assign cur         = mem[scan_ptr];
    assign busy        = (state == COLLECT) || (state == SCAN);
    assign sel_done    = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start always (re)enters COLLECT; DONE lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: begin
                if (start)            state_next = COLLECT;
                else if (last_accept) state_next = SCAN;
            end
            SCAN: begin
                if (start)          state_next = COLLECT;
                else if (scan_last) state_next = DONE;
            end
            DONE:    state_next = start ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Distance storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[count[IDX_W-1:0]] <= dist_in;
        end
    end

    // Counters, overflow flag and running best/second-best during SCAN
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            overflow    <= 1'b0;
            scan_ptr    <= '0;
            best_idx    <= '0;
            best_dist   <= '0;
            second_idx  <= '0;
            second_dist <= '0;
        end else if (start) begin
            // A dist arriving with start outside COLLECT is still a stray
            count    <= '0;
            scan_ptr <= '0;
            overflow <= (state != COLLECT) && dist_valid;
        end else begin
            case (state)
                COLLECT: begin
                    scan_ptr <= '0;
                    if (dist_valid) begin
                        count <= count + (IDX_W+1)'(1);
                    end
                end
                SCAN: begin
                    if (dist_valid) begin
                        overflow <= 1'b1;
                    end
                    scan_ptr <= scan_ptr + IDX_W'(1);
                    if (scan_ptr == '0) begin
                        best_dist <= cur;
                        best_idx  <= '0;
                    end else if (scan_ptr == IDX_W'(1)) begin
                        // second is still stale here, so the new entry fills it unconditionally
                        if (cur < best_dist) begin
                            best_dist   <= cur;
                            best_idx    <= scan_ptr;
                            second_dist <= best_dist;
                            second_idx  <= best_idx;
                        end else begin
                            second_dist <= cur;
                            second_idx  <= scan_ptr;
                        end
                    end else if (cur < best_dist) begin
                        best_dist   <= cur;
                        best_idx    <= scan_ptr;
                        second_dist <= best_dist;
                        second_idx  <= best_idx;
                    end else if (cur < second_dist) begin
                        second_dist <= cur;
                        second_idx  <= scan_ptr;
                    end
                end
                default: begin
                    if (dist_valid) begin
                        overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_select_parents.sv
// tb/tb_select_parents.sv - directed self-checking bench for select_parents
module tb_select_parents;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        dist_valid;
    logic [11:0] dist_in;
    logic [3:0]  count;
    logic        busy;
    logic        sel_done;
    logic [2:0]  best_idx;
    logic [11:0] best_dist;
    logic [2:0]  second_idx;
    logic [11:0] second_dist;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [11:0] gd [8];

    select_parents #(.POP_SIZE(8), .IDX_W(3), .DIST_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .dist_valid(dist_valid),
        .dist_in(dist_in), .count(count), .busy(busy), .sel_done(sel_done),
        .best_idx(best_idx), .best_dist(best_dist), .second_idx(second_idx),
        .second_dist(second_dist), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (sel_done) pulses++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Sends gd[0..7]; lat = cycles from the 8th valid to the sel_done cycle (40 = timeout)
    task automatic send_and_wait(output int lat);
        for (int k = 0; k < 8; k++) begin
            dist_valid = 1'b1;
            dist_in    = gd[k];
            step();
        end
        dist_valid = 1'b0;
        lat = 1;
        while (!sel_done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (count !== 4'd0)       begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (sel_done !== 1'b0)    begin errors++; $display("FAIL reset_sel_done got %0b want 0", sel_done); end
        checks++; if (best_idx !== 3'd0)    begin errors++; $display("FAIL reset_best_idx got %0d want 0", best_idx); end
        checks++; if (best_dist !== 12'd0)  begin errors++; $display("FAIL reset_best_dist got %0d want 0", best_dist); end
        checks++; if (second_idx !== 3'd0)  begin errors++; $display("FAIL reset_second_idx got %0d want 0", second_idx); end
        checks++; if (second_dist !== 12'd0) begin errors++; $display("FAIL reset_second_dist got %0d want 0", second_dist); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_order();
        int lat;
        gd = '{12'd900, 12'd300, 12'd700, 12'd100, 12'd500, 12'd800, 12'd200, 12'd600};
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL order_busy got %0b want 1", busy); end
        send_and_wait(lat);
        checks++; if (lat !== 9)             begin errors++; $display("FAIL order_latency got %0d want 9", lat); end
        checks++; if (best_idx !== 3'd3)     begin errors++; $display("FAIL order_best_idx got %0d want 3", best_idx); end
        checks++; if (best_dist !== 12'd100) begin errors++; $display("FAIL order_best_dist got %0d want 100", best_dist); end
        checks++; if (second_idx !== 3'd6)   begin errors++; $display("FAIL order_second_idx got %0d want 6", second_idx); end
        checks++; if (second_dist !== 12'd200) begin errors++; $display("FAIL order_second_dist got %0d want 200", second_dist); end
        checks++; if (count !== 4'd8)        begin errors++; $display("FAIL order_count got %0d want 8", count); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL order_busy_done got %0b want 0", busy); end
        step();
        checks++; if (sel_done !== 1'b0)     begin errors++; $display("FAIL order_pulse_width got %0b want 0", sel_done); end
        checks++; if (best_idx !== 3'd3)     begin errors++; $display("FAIL order_hold_best got %0d want 3", best_idx); end
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL order_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_ties();
        int lat;
        for (int k = 0; k < 8; k++) gd[k] = 12'd4095;
        pulse_start();
        send_and_wait(lat);
        checks++; if (lat !== 9)              begin errors++; $display("FAIL ties_latency got %0d want 9", lat); end
        checks++; if (best_idx !== 3'd0)      begin errors++; $display("FAIL ties_best_idx got %0d want 0", best_idx); end
        checks++; if (best_dist !== 12'd4095) begin errors++; $display("FAIL ties_best_dist got %0d want 4095", best_dist); end
        checks++; if (second_idx !== 3'd1)    begin errors++; $display("FAIL ties_second_idx got %0d want 1", second_idx); end
        checks++; if (second_dist !== 12'd4095) begin errors++; $display("FAIL ties_second_dist got %0d want 4095", second_dist); end
        step();
    endtask

    task automatic test_abort();
        int lat;
        pulses = 0;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            dist_valid = 1'b1;
            dist_in    = 12'd1;
            step();
        end
        dist_valid = 1'b0;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL abort_partial_count got %0d want 5", count); end
        pulse_start();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL abort_count got %0d want 0", count); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL abort_busy got %0b want 1", busy); end
        for (int k = 0; k < 8; k++) gd[k] = 12'(10 * (k + 1));
        send_and_wait(lat);
        for (int k = 0; k < 3; k++) step();
        checks++; if (pulses !== 1)          begin errors++; $display("FAIL abort_pulses got %0d want 1", pulses); end
        checks++; if (best_idx !== 3'd0)     begin errors++; $display("FAIL abort_best_idx got %0d want 0", best_idx); end
        checks++; if (best_dist !== 12'd10)  begin errors++; $display("FAIL abort_best_dist got %0d want 10", best_dist); end
        checks++; if (second_idx !== 3'd1)   begin errors++; $display("FAIL abort_second_idx got %0d want 1", second_idx); end
        checks++; if (second_dist !== 12'd20) begin errors++; $display("FAIL abort_second_dist got %0d want 20", second_dist); end
    endtask

    task automatic test_stray();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        dist_valid = 1'b1;
        dist_in    = 12'd77;
        step();
        dist_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stray_overflow got %0b want 1", overflow); end
        checks++; if (count !== 4'd0)    begin errors++; $display("FAIL stray_count got %0d want 0", count); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL stray_busy got %0b want 0", busy); end
        pulse_start();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stray_clear got %0b want 0", overflow); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL stray_collect got %0b want 1", busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        start      = 1'b1;
        dist_valid = 1'b1;
        step();
        start      = 1'b0;
        dist_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL start_stray_overflow got %0b want 1", overflow); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL start_stray_busy got %0b want 1", busy); end
        checks++; if (count !== 4'd0)    begin errors++; $display("FAIL start_stray_count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        int lat;
        gd = '{12'd900, 12'd300, 12'd700, 12'd100, 12'd500, 12'd800, 12'd200, 12'd600};
        pulse_start();
        send_and_wait(lat);
        checks++; if (sel_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %0b want 1", sel_done); end
        pulse_start();
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL b2b_busy got %0b want 1", busy); end
        checks++; if (count !== 4'd0)    begin errors++; $display("FAIL b2b_count got %0d want 0", count); end
        gd = '{12'd50, 12'd40, 12'd30, 12'd20, 12'd60, 12'd70, 12'd80, 12'd90};
        send_and_wait(lat);
        checks++; if (lat !== 9)             begin errors++; $display("FAIL b2b_latency got %0d want 9", lat); end
        checks++; if (best_idx !== 3'd3)     begin errors++; $display("FAIL b2b_best_idx got %0d want 3", best_idx); end
        checks++; if (best_dist !== 12'd20)  begin errors++; $display("FAIL b2b_best_dist got %0d want 20", best_dist); end
        checks++; if (second_idx !== 3'd2)   begin errors++; $display("FAIL b2b_second_idx got %0d want 2", second_idx); end
        checks++; if (second_dist !== 12'd30) begin errors++; $display("FAIL b2b_second_dist got %0d want 30", second_dist); end
        step();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            dist_valid = 1'b1;
            dist_in    = 12'd5;
            step();
        end
        dist_valid = 1'b0;
        reset = 1'b1;
        step();
        checks++; if (count !== 4'd0)       begin errors++; $display("FAIL mid_reset_count got %0d want 0", count); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mid_reset_busy got %0b want 0", busy); end
        checks++; if (best_dist !== 12'd0)  begin errors++; $display("FAIL mid_reset_best_dist got %0d want 0", best_dist); end
        checks++; if (second_idx !== 3'd0)  begin errors++; $display("FAIL mid_reset_second_idx got %0d want 0", second_idx); end
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        dist_valid = 1'b0;
        dist_in    = '0;
        test_reset();
        test_order();
        test_ties();
        test_abort();
        test_stray();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
